// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl_if
//  Description : Data-memory request/acknowledge bus. The MEM stage drives
//                the request side (master); the memory answers (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM pipeline stage. Performs the data-memory access with
//                wait states (stalling upstream), resolves branch/jump into a
//                PC redirect + flush, and registers the MEM/WB bundle.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 32,
    parameter int REGA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [DATA_W-1:0] MEM_aluout,
    input  wire logic [DATA_W-1:0] MEM_read_data2,
    input  wire logic [REGA_W-1:0] MEM_reg_write_addr,
    input  wire logic [ADDR_W-1:0] MEM_branch_addr,
    input  wire logic [ADDR_W-1:0] MEM_jump_addr,
    input  wire logic              MEM_zr,
    input  wire logic              MEM_ng,
    input  wire logic              MEM_cr,
    input  wire logic              MEM_ov,
    input  wire logic              MEM_Branch,
    input  wire logic              MEM_BranchFlip,
    input  wire logic              MEM_MemRead,
    input  wire logic              MEM_MemWrite,
    input  wire logic              MEM_Jump,
    input  wire logic              MEM_RegWrite,
    input  wire logic              MEM_MemtoReg,
    mem_stage_ctrl_if.master       dmem,
    output logic                   stall,
    output logic                   pc_redirect,
    output logic [ADDR_W-1:0]      pc_target,
    output logic                   flush,
    output logic                   WB_RegWrite,
    output logic [REGA_W-1:0]      WB_reg_write_addr,
    output logic [DATA_W-1:0]      WB_wdata,
    output logic                   bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter only needs to reach MAX_WAIT-1; keep at least one bit.
    localparam int               CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam bit               TIMEOUT_EN = (MAX_WAIT != 0);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              abort;
    logic [DATA_W-1:0] rdata_q;
    logic              req_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem;
    logic              take;

    // Flags other than zero are carried in the bundle but never consulted.
    logic unused_flags;
    assign unused_flags = &{1'b0, MEM_ng, MEM_cr, MEM_ov};

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    // Stall while an access is being launched or is outstanding; redirect only on retire.
    always_comb begin
        mem         = MEM_MemRead | MEM_MemWrite;
        stall       = ((state == IDLE) & mem) | (state == WAIT);
        take        = MEM_Jump | (MEM_Branch & (MEM_zr ^ MEM_BranchFlip));
        pc_redirect = ~stall & take;
        flush       = pc_redirect;
        pc_target   = (~stall & MEM_Jump) ? MEM_jump_addr : MEM_branch_addr;
    end

    // Access FSM: launch request, wait for ack or timeout, then one retire cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            abort   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem) begin
                        req_q   <= 1'b1;
                        we_q    <= MEM_MemWrite;
                        addr_q  <= MEM_aluout;
                        wdata_q <= MEM_read_data2;
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Ack takes priority over a simultaneous timeout.
                    if (dmem.ack) begin
                        req_q   <= 1'b0;
                        rdata_q <= dmem.rdata;
                        abort   <= 1'b0;
                        state   <= DONE;
                    end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                        req_q   <= 1'b0;
                        abort   <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: capture on retire, insert a bubble on every stall edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_RegWrite       <= 1'b0;
            WB_reg_write_addr <= '0;
            WB_wdata          <= '0;
        end else if (stall) begin
            WB_RegWrite <= 1'b0;
        end else begin
            // An aborted load has no valid data, so its register write is dropped.
            WB_RegWrite       <= MEM_RegWrite & ~((state == DONE) & abort & MEM_MemRead);
            WB_reg_write_addr <= MEM_reg_write_addr;
            WB_wdata          <= MEM_MemtoReg ? rdata_q : MEM_aluout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Directed self-checking bench for mem_stage_ctrl (MAX_WAIT=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  MEM_aluout;
    logic [7:0]  MEM_read_data2;
    logic [31:0] MEM_reg_write_addr;
    logic [31:0] MEM_branch_addr;
    logic [31:0] MEM_jump_addr;
    logic        MEM_zr, MEM_ng, MEM_cr, MEM_ov;
    logic        MEM_Branch, MEM_BranchFlip, MEM_MemRead, MEM_MemWrite;
    logic        MEM_Jump, MEM_RegWrite, MEM_MemtoReg;
    logic        stall, pc_redirect, flush, WB_RegWrite, bus_err;
    logic [31:0] pc_target;
    logic [31:0] WB_reg_write_addr;
    logic [7:0]  WB_wdata;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl_if #(.DATA_W(8)) bus ();

    mem_stage_ctrl #(
        .DATA_W(8), .ADDR_W(32), .REGA_W(32), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_aluout(MEM_aluout), .MEM_read_data2(MEM_read_data2),
        .MEM_reg_write_addr(MEM_reg_write_addr),
        .MEM_branch_addr(MEM_branch_addr), .MEM_jump_addr(MEM_jump_addr),
        .MEM_zr(MEM_zr), .MEM_ng(MEM_ng), .MEM_cr(MEM_cr), .MEM_ov(MEM_ov),
        .MEM_Branch(MEM_Branch), .MEM_BranchFlip(MEM_BranchFlip),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_Jump(MEM_Jump), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .dmem(bus),
        .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
        .WB_RegWrite(WB_RegWrite), .WB_reg_write_addr(WB_reg_write_addr),
        .WB_wdata(WB_wdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MEM_aluout = '0; MEM_read_data2 = '0; MEM_reg_write_addr = '0;
        MEM_branch_addr = '0; MEM_jump_addr = '0;
        MEM_zr = 0; MEM_ng = 0; MEM_cr = 0; MEM_ov = 0;
        MEM_Branch = 0; MEM_BranchFlip = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
        MEM_Jump = 0; MEM_RegWrite = 0; MEM_MemtoReg = 0;
        bus.ack = 0; bus.rdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        // Reset state
        chk("rst_req",     bus.req,           1'b0);
        chk("rst_we",      bus.we,            1'b0);
        chk("rst_addr",    bus.addr,          8'h00);
        chk("rst_wbrw",    WB_RegWrite,       1'b0);
        chk("rst_wbdata",  WB_wdata,          8'h00);
        chk("rst_buserr",  bus_err,           1'b0);
        chk("rst_stall",   stall,             1'b0);
        rst_n = 1'b1;

        // ALU op retires in one cycle
        MEM_RegWrite = 1; MEM_aluout = 8'h5A; MEM_reg_write_addr = 32'd3;
        #1 chk("alu_stall", stall, 1'b0);
        tick();
        chk("alu_wbrw",   WB_RegWrite,       1'b1);
        chk("alu_wbdata", WB_wdata,          8'h5A);
        chk("alu_wbaddr", WB_reg_write_addr, 32'd3);

        // Load, ack after two wait cycles
        MEM_MemRead = 1; MEM_MemtoReg = 1; MEM_RegWrite = 1;
        MEM_aluout = 8'h10; MEM_reg_write_addr = 32'd5;
        #1 chk("ld_stall0", stall, 1'b1);
        tick();
        chk("ld_req",   bus.req,     1'b1);
        chk("ld_we",    bus.we,      1'b0);
        chk("ld_addr",  bus.addr,    8'h10);
        chk("ld_bub1",  WB_RegWrite, 1'b0);
        chk("ld_stall1", stall,      1'b1);
        tick();
        chk("ld_req2",  bus.req,     1'b1);
        chk("ld_bub2",  WB_RegWrite, 1'b0);
        tick();
        chk("ld_stall3", stall,      1'b1);
        chk("ld_bub3",  WB_RegWrite, 1'b0);
        bus.ack = 1; bus.rdata = 8'hC3;
        tick();
        bus.ack = 0; bus.rdata = 8'h00;
        chk("ld_reqdrop", bus.req,    1'b0);
        chk("ld_done_st", stall,      1'b0);
        chk("ld_bub4",    WB_RegWrite, 1'b0);
        tick();
        chk("ld_wbrw",   WB_RegWrite,       1'b1);
        chk("ld_wbdata", WB_wdata,          8'hC3);
        chk("ld_wbaddr", WB_reg_write_addr, 32'd5);

        // Store, ack on the first WAIT cycle
        MEM_MemRead = 0; MEM_MemtoReg = 0; MEM_RegWrite = 0;
        MEM_MemWrite = 1; MEM_aluout = 8'h20; MEM_read_data2 = 8'h7E;
        tick();
        chk("st_req",   bus.req,     1'b1);
        chk("st_we",    bus.we,      1'b1);
        chk("st_addr",  bus.addr,    8'h20);
        chk("st_wdata", bus.wdata,   8'h7E);
        bus.ack = 1;
        tick();
        bus.ack = 0;
        chk("st_req1cyc", bus.req, 1'b0);
        chk("st_stall",   stall,   1'b0);
        tick();
        chk("st_wbrw", WB_RegWrite, 1'b0);

        // Load that never gets an ack: aborts after 4 WAIT cycles
        MEM_MemWrite = 0; MEM_MemRead = 1; MEM_MemtoReg = 1; MEM_RegWrite = 1;
        MEM_aluout = 8'h30; MEM_reg_write_addr = 32'd7;
        tick();
        chk("to_req0", bus.req, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("to_reqw", bus.req, 1'b1);
        end
        tick();
        chk("to_reqdrop", bus.req,  1'b0);
        chk("to_buserr",  bus_err,  1'b1);
        chk("to_stall",   stall,    1'b0);
        tick();
        chk("to_nowb",    WB_RegWrite, 1'b0);
        clear_inputs();
        tick();
        chk("to_sticky",  bus_err,  1'b1);

        // Branch / jump redirect
        MEM_Branch = 1; MEM_zr = 1; MEM_branch_addr = 32'h40; MEM_jump_addr = 32'h80;
        #1;
        chk("br_redir",  pc_redirect, 1'b1);
        chk("br_flush",  flush,       1'b1);
        chk("br_target", pc_target,   32'h40);
        MEM_BranchFlip = 1;
        #1;
        chk("brf_redir", pc_redirect, 1'b0);
        chk("brf_flush", flush,       1'b0);
        MEM_BranchFlip = 0; MEM_Jump = 1;
        #1;
        chk("jmp_redir",  pc_redirect, 1'b1);
        chk("jmp_target", pc_target,   32'h80);
        clear_inputs();

        // Reset asserted during WAIT
        MEM_MemRead = 1; MEM_aluout = 8'h44;
        tick();
        chk("rw_req", bus.req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_reqdrop", bus.req,           1'b0);
        chk("rw_buserr",  bus_err,           1'b0);
        chk("rw_wbrw",    WB_RegWrite,       1'b0);
        chk("rw_wbdata",  WB_wdata,          8'h00);
        chk("rw_wbaddr",  WB_reg_write_addr, 32'd0);
        chk("rw_addr",    bus.addr,          8'h00);
        clear_inputs();
        #1 rst_n = 1'b1;
        tick();
        chk("rw_idle",    stall,   1'b0);
        chk("rw_req2",    bus.req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
